pc_seq_unit: RTL and testbench
==============================

// Module: pc_seq_unit
// PURPOSE
//  Parametrised program-counter sequencer for the 16-bit core; successor to the 8-bit PC block.
//  Adds configurable PC width, a relative jump with a signed offset, flag-conditional branches with
//  condition inversion, absolute jump, and call/return through an internal LIFO return stack.
//  Sits between the decoder (op/cond/offset/target) and the ALU flag register; drives the instruction-memory address.
// PARAMETERS
//  PC_W      8   PC / address width in bits (4..16)
//  OFF_W     9   relative-offset width, two's complement (2..PC_W+1)
//  STK_DEPTH 4   return-stack entries (1..16)
//  RESET_VEC 0   PC value loaded on reset
// PORTS
//  clk       in   1        clock; all state updates on rising edge
//  rst_n     in   1        asynchronous, active-low reset
//  en        in   1        1 = advance this cycle; 0 = stall (all state holds)
//  op        in   3        0 NEXT, 1 JREL, 2 BCOND, 3 CALL, 4 RET, 5 JABS, 6-7 reserved (as NEXT)
//  cond      in   3        BCOND select: 0 always, 1 neg, 2 zer, 3 ovf, 4 car, 5-7 reserved (never)
//  cond_inv  in   1        BCOND only: invert the selected flag test (ignored for cond 0 and 5-7)
//  neg       in   1        ALU negative flag
//  zer       in   1        ALU zero flag
//  ovf       in   1        ALU overflow flag
//  car       in   1        ALU carry flag
//  offset    in   OFF_W    JREL signed displacement
//  target    in   PC_W+1   BCOND/CALL/JABS absolute destination; only low PC_W bits used
//  pc_out    out  PC_W     current PC (registered)
//  taken     out  1        registered; 1 for the cycle after any non-sequential PC update
//  stk_cnt   out  5        number of valid return-stack entries
//  stk_err   out  1        sticky; set on CALL-when-full or RET-when-empty; cleared only by reset
// BEHAVIOUR
//  Reset (rst_n=0, async)
//   - pc_out=RESET_VEC, taken=0, stk_cnt=0, stk_err=0; stack contents don't-care.
//   - Reset asserted mid-stream overrides everything immediately; first update occurs on the first rising edge after rst_n=1.
//  Stall
//   - en=0: pc, stack, stk_cnt and stk_err hold; taken is driven 0.
//  Per-op update (en=1), with inc = pc+1 mod 2^PC_W:
//   - NEXT: pc<=inc; taken<=0.
//   - JREL: pc<=pc + sext(offset) mod 2^PC_W; taken<=1 (even when offset=0).
//   - BCOND: t = (cond==0) ? 1 : (cond in 1-4) ? flag^cond_inv : 0.
//     t=1: pc<=target[PC_W-1:0], taken<=1. t=0: pc<=inc, taken<=0.
//   - JABS: pc<=target[PC_W-1:0]; taken<=1.
//   - CALL, stk_cnt<STK_DEPTH: push inc, stk_cnt+1, pc<=target, taken<=1.
//   - CALL, stk full: no push, pc<=inc, taken<=0, stk_err<=1.
//   - RET, stk_cnt>0: pop top entry into pc, stk_cnt-1, taken<=1.
//   - RET, stk empty: pc<=inc, taken<=0, stk_err<=1.
//  Flags
//   - Sampled combinationally in the same cycle as op; no internal flag registers; latency 1 cycle, op to pc_out.
//  Arithmetic
//   - All PC arithmetic wraps modulo 2^PC_W, with no carry-out indication: max+1 -> 0; a negative offset below 0 wraps to the top.
//  Stack
//   - Strict LIFO; push and pop never occur in the same cycle (single op).
//   - CALL with target equal to the current pc is legal.
// TESTING
//  1 Reset: rst_n=0 mid-run with pc=0x37 -> pc_out=RESET_VEC, stk_cnt=0, stk_err=0 without waiting for clk.
//  2 Sequence/wrap: PC_W=8, 300 NEXT cycles from reset -> pc_out=0xFF then 0x00, 0x01; taken=0 throughout; en=0 for 3 cycles holds pc.
//  3 JREL: pc=0x10, offset=9'h1FC (-4) -> 0x0C, taken=1; pc=0xFE, offset=+5 -> 0x03.
//  4 BCOND: cond=2, zer=1 -> pc=target; cond=2, zer=1, cond_inv=1 -> pc+1, taken=0; cond=6 -> pc+1; cond=0 -> target.
//  5 Call/return: 4 nested CALLs from pc 0x05,0x20,0x30,0x40 -> stk_cnt=4; 4 RETs return 0x41,0x31,0x21,0x06; 5th RET -> pc+1, stk_err=1.
//  6 Overflow: STK_DEPTH=4 full, CALL target=0x80 at pc=0x50 -> pc=0x51, stk_cnt=4, stk_err=1 and stays set until reset.

Source files
------------

// File: rtl/pc_seq_unit.sv
// pc_seq_unit: program-counter sequencer with relative/absolute jumps, flag branches and a LIFO call stack
module pc_seq_unit #(
  parameter int PC_W      = 8,
  parameter int OFF_W     = 9,
  parameter int STK_DEPTH = 4,
  parameter int RESET_VEC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [2:0]        op,
  input  logic [2:0]        cond,
  input  logic              cond_inv,
  input  logic              neg,
  input  logic              zer,
  input  logic              ovf,
  input  logic              car,
  input  logic [OFF_W-1:0]  offset,
  input  logic [PC_W:0]     target,
  output logic [PC_W-1:0]   pc_out,
  output logic              taken,
  output logic [4:0]        stk_cnt,
  output logic              stk_err
);
  localparam logic [PC_W-1:0] RV    = RESET_VEC[PC_W-1:0];
  localparam logic [PC_W-1:0] ONE   = 1;
  localparam logic [4:0]      DEPTH = 5'(STK_DEPTH);
  localparam int              AW    = STK_DEPTH > 1 ? $clog2(STK_DEPTH) : 1;
  logic [PC_W-1:0] stk [STK_DEPTH];
  logic [PC_W+OFF_W-1:0] off_wide;
  logic [PC_W-1:0] inc, rel, tgt, nxt_pc;
  logic [4:0] top;
  logic flag, hit, full, empty, nxt_taken, push, pop, err_set;
  logic unused_bits;
  assign off_wide    = {{PC_W{offset[OFF_W-1]}}, offset};
  assign inc         = pc_out + ONE;
  assign rel         = pc_out + off_wide[PC_W-1:0];
  assign tgt         = target[PC_W-1:0];
  assign top         = stk_cnt - 5'd1;
  assign full        = stk_cnt >= DEPTH;
  assign empty       = stk_cnt == 5'd0;
  assign flag        = cond == 3'd1 ? neg : cond == 3'd2 ? zer : cond == 3'd3 ? ovf : car;
  assign hit         = cond == 3'd0 ? 1'b1 : cond <= 3'd4 ? flag ^ cond_inv : 1'b0;
  assign unused_bits = ^{target[PC_W], top, off_wide[PC_W+OFF_W-1:PC_W]};
  always_comb begin
    nxt_pc    = inc;
    nxt_taken = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    err_set   = 1'b0;
    case (op)
      3'd1: begin
        nxt_pc    = rel;
        nxt_taken = 1'b1;
      end
      3'd2: begin
        nxt_pc    = hit ? tgt : inc;
        nxt_taken = hit;
      end
      3'd3: begin
        push      = !full;
        err_set   = full;
        nxt_pc    = full ? inc : tgt;
        nxt_taken = !full;
      end
      3'd4: begin
        pop       = !empty;
        err_set   = empty;
        nxt_pc    = empty ? inc : stk[top[AW-1:0]];
        nxt_taken = !empty;
      end
      3'd5: begin
        nxt_pc    = tgt;
        nxt_taken = 1'b1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out  <= RV;
      taken   <= 1'b0;
      stk_cnt <= 5'd0;
      stk_err <= 1'b0;
    end else if (en) begin
      pc_out  <= nxt_pc;
      taken   <= nxt_taken;
      stk_cnt <= push ? stk_cnt + 5'd1 : pop ? top : stk_cnt;
      stk_err <= stk_err | err_set;
    end else begin
      taken <= 1'b0;
    end
  end
  // stack storage needs no reset: entries are only read below stk_cnt
  always_ff @(posedge clk) begin
    if (en && push) stk[stk_cnt[AW-1:0]] <= inc;
  end
endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: directed and random checks of pc_seq_unit against a queue-based reference model
module tb_pc_seq_unit;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, cond_inv = 1'b0;
  logic neg = 1'b0, zer = 1'b0, ovf = 1'b0, car = 1'b0;
  logic [2:0] op = 3'd0, cond = 3'd0;
  logic [8:0] offset = 9'd0, target = 9'd0;
  logic [7:0] pc_out;
  logic taken, stk_err;
  logic [4:0] stk_cnt;
  int n_tests = 0, n_fail = 0;
  int m_pc = 0;
  bit m_taken = 0, m_err = 0;
  int stk[$];

  pc_seq_unit #(.PC_W(8), .OFF_W(9), .STK_DEPTH(4), .RESET_VEC(0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op), .cond(cond), .cond_inv(cond_inv),
    .neg(neg), .zer(zer), .ovf(ovf), .car(car), .offset(offset), .target(target),
    .pc_out(pc_out), .taken(taken), .stk_cnt(stk_cnt), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"}, 32'(pc_out), m_pc);
    check({tag, ".taken"}, 32'(taken), 32'(m_taken));
    check({tag, ".cnt"}, 32'(stk_cnt), stk.size());
    check({tag, ".err"}, 32'(stk_err), 32'(m_err));
  endtask

  // fl = {car, ovf, zer, neg}, so cond c selects fl[c-1]
  task automatic cyc(input string tag, input logic e, input logic [2:0] o, input logic [2:0] c,
                     input logic ci, input logic [3:0] fl, input logic [8:0] off, input logic [8:0] tg);
    int inc, so;
    bit t;
    en = e; op = o; cond = c; cond_inv = ci; {car, ovf, zer, neg} = fl; offset = off; target = tg;
    inc = (m_pc + 1) & 255;
    m_taken = 0;
    if (e) begin
      case (o)
        3'd1: begin
          so = off[8] ? int'(off) - 512 : int'(off);
          m_pc = (m_pc + so) & 255;
          m_taken = 1;
        end
        3'd2: begin
          t = (c == 0) ? 1'b1 : (c <= 4) ? (fl[c-1] ^ ci) : 1'b0;
          m_pc = t ? int'(tg[7:0]) : inc;
          m_taken = t;
        end
        3'd3: begin
          if (stk.size() < 4) begin
            stk.push_back(inc);
            m_pc = tg[7:0];
            m_taken = 1;
          end else begin
            m_pc = inc;
            m_err = 1;
          end
        end
        3'd4: begin
          if (stk.size() > 0) begin
            m_pc = stk.pop_back();
            m_taken = 1;
          end else begin
            m_pc = inc;
            m_err = 1;
          end
        end
        3'd5: begin
          m_pc = tg[7:0];
          m_taken = 1;
        end
        default: m_pc = inc;
      endcase
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic nxt(input string tag);
    cyc(tag, 1'b1, 3'd0, 3'd0, 1'b0, 4'h0, 9'd0, 9'd0);
  endtask

  task automatic jabs(input logic [8:0] tg);
    cyc("jabs", 1'b1, 3'd5, 3'd0, 1'b0, 4'h0, 9'd0, tg);
  endtask

  // asserts reset between edges and checks outputs before any clock edge arrives
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    m_pc = 0; m_taken = 0; m_err = 0;
    stk.delete();
    #1;
    check_all(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    check_all("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 55; i++) nxt("t1_run");
    check("t1_pc37", 32'(pc_out), 32'h37);
    do_reset("t1_rst");
    for (int i = 0; i < 300; i++) begin
      nxt("t2_next");
      if (i == 254) check("t2_ff", 32'(pc_out), 32'hFF);
      if (i == 255) check("t2_wrap", 32'(pc_out), 32'h00);
    end
    for (int i = 0; i < 3; i++) cyc("t2_stall", 1'b0, 3'd5, 3'd0, 1'b0, 4'h0, 9'd0, 9'h0AA);
    jabs(9'h010);
    cyc("t3_jrel_neg", 1'b1, 3'd1, 3'd0, 1'b0, 4'h0, 9'h1FC, 9'd0);
    check("t3_0c", 32'(pc_out), 32'h0C);
    jabs(9'h0FE);
    cyc("t3_jrel_wrap", 1'b1, 3'd1, 3'd0, 1'b0, 4'h0, 9'd5, 9'd0);
    check("t3_03", 32'(pc_out), 32'h03);
    cyc("t3_jrel_zero", 1'b1, 3'd1, 3'd0, 1'b0, 4'h0, 9'd0, 9'd0);
    cyc("t4_zer", 1'b1, 3'd2, 3'd2, 1'b0, 4'b0010, 9'd0, 9'h1A0);
    cyc("t4_zer_inv", 1'b1, 3'd2, 3'd2, 1'b1, 4'b0010, 9'd0, 9'h0B0);
    cyc("t4_cond6", 1'b1, 3'd2, 3'd6, 1'b1, 4'b1111, 9'd0, 9'h0C0);
    cyc("t4_cond0", 1'b1, 3'd2, 3'd0, 1'b1, 4'b0000, 9'd0, 9'h0D0);
    check("t4_d0", 32'(pc_out), 32'hD0);
    do_reset("t5_rst");
    jabs(9'h005);
    cyc("t5_call1", 1'b1, 3'd3, 3'd0, 1'b0, 4'h0, 9'd0, 9'h020);
    cyc("t5_call2", 1'b1, 3'd3, 3'd0, 1'b0, 4'h0, 9'd0, 9'h030);
    cyc("t5_call3", 1'b1, 3'd3, 3'd0, 1'b0, 4'h0, 9'd0, 9'h040);
    cyc("t5_call4", 1'b1, 3'd3, 3'd0, 1'b0, 4'h0, 9'd0, 9'h060);
    check("t5_cnt4", 32'(stk_cnt), 4);
    for (int i = 0; i < 4; i++) cyc("t5_ret", 1'b1, 3'd4, 3'd0, 1'b0, 4'h0, 9'd0, 9'd0);
    check("t5_ret06", 32'(pc_out), 32'h06);
    cyc("t5_ret_empty", 1'b1, 3'd4, 3'd0, 1'b0, 4'h0, 9'd0, 9'd0);
    check("t5_07", 32'(pc_out), 32'h07);
    do_reset("t6_rst");
    for (int i = 0; i < 4; i++) cyc("t6_fill", 1'b1, 3'd3, 3'd0, 1'b0, 4'h0, 9'd0, 9'(i * 16));
    jabs(9'h050);
    cyc("t6_ovf", 1'b1, 3'd3, 3'd0, 1'b0, 4'h0, 9'd0, 9'h080);
    check("t6_51", 32'(pc_out), 32'h51);
    check("t6_err", 32'(stk_err), 1);
    for (int i = 0; i < 3; i++) nxt("t6_sticky");
    do_reset("t6_clear");
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) do_reset("rnd_rst");
      cyc("rnd", ($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
          1'($urandom), 4'($urandom), 9'($urandom), 9'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
